// File: rtl/relu_pool_if.sv
// Handshake and data bundle between a convolution stream source and relu_pool.
// The source side takes the master modport, the pooling block the slave modport.
interface relu_pool_if;
    logic               POOL_start;
    logic               POOL_iValid;
    logic signed [19:0] POOL_iData;
    logic               POOL_oValid;
    logic signed [7:0]  POOL_oData;
    logic               POOL_busy;
    logic               POOL_finish;

    modport master (
        output POOL_start,
        output POOL_iValid,
        output POOL_iData,
        input  POOL_oValid,
        input  POOL_oData,
        input  POOL_busy,
        input  POOL_finish
    );

    modport slave (
        input  POOL_start,
        input  POOL_iValid,
        input  POOL_iData,
        output POOL_oValid,
        output POOL_oData,
        output POOL_busy,
        output POOL_finish
    );
endinterface

// File: rtl/relu_pool.sv
// 2x2 max-pooling over a 4x4 frame of signed 20-bit convolution results,
// followed by ReLU, an arithmetic right shift by SHIFT and saturation to a
// signed 8-bit result. Samples arrive row-major; even rows leave one pair
// maximum per column pair in a small row buffer, and odd rows combine their
// pair maximum with that buffered value to complete a window.
module relu_pool #(
    parameter int SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset,
    relu_pool_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         row_q, row_d;
    logic [1:0]         col_q, col_d;
    logic signed [19:0] pair_q, pair_d;
    logic signed [19:0] rowBuf_q [2];
    logic signed [19:0] rowBuf_d [2];
    logic               oValid_q, oValid_d;
    logic signed [7:0]  oData_q, oData_d;

    logic               accept;
    logic               restart;
    logic               trigger;
    logic signed [19:0] sample;
    logic signed [19:0] pairMax;
    logic signed [19:0] bufVal;
    logic signed [19:0] winMax;
    logic signed [19:0] relu;
    logic signed [19:0] scaled;
    logic signed [7:0]  saturated;

    // Decode the handshake: a start in IDLE or ACCEPT (re)arms the frame and
    // swallows any sample presented with it; samples only count in ACCEPT.
    always_comb begin
        sample  = bus.POOL_iData;
        restart = bus.POOL_start && (state_q != DONE);
        accept  = (state_q == ACCEPT) && !bus.POOL_start && bus.POOL_iValid;
        trigger = accept && row_q[0] && col_q[0];
    end

    // Max/ReLU/scale/saturate chain, all kept at full 20-bit signed width.
    always_comb begin
        pairMax   = (sample > pair_q) ? sample : pair_q;
        bufVal    = rowBuf_q[col_q[1]];
        winMax    = (bufVal > pairMax) ? bufVal : pairMax;
        relu      = winMax[19] ? 20'sd0 : winMax;
        scaled    = relu >>> SHIFT;
        saturated = (scaled > 20'sd127) ? 8'sd127 : scaled[7:0];
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame sequencing: the 16th accepted sample ends the frame, DONE lasts
    // exactly one cycle so the finish pulse lines up with the last result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.POOL_start) begin
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (bus.POOL_start) begin
                    state_d = ACCEPT;
                end else if (accept && (row_q == 2'd3) && (col_q == 2'd3)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values for the counters, pair/row storage and the output register.
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        pair_d      = pair_q;
        rowBuf_d[0] = rowBuf_q[0];
        rowBuf_d[1] = rowBuf_q[1];
        oValid_d    = trigger;
        oData_d     = oData_q;
        if (restart) begin
            row_d       = 2'd0;
            col_d       = 2'd0;
            pair_d      = 20'sd0;
            rowBuf_d[0] = 20'sd0;
            rowBuf_d[1] = 20'sd0;
        end else if (accept) begin
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
                row_d = row_q + 2'd1;
            end
            if (!col_q[0]) begin
                pair_d = sample;
            end else if (!row_q[0]) begin
                rowBuf_d[col_q[1]] = pairMax;
            end
        end
        if (trigger) begin
            oData_d = saturated;
        end
    end

    // Datapath registers; output data holds between results.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q       <= 2'd0;
            col_q       <= 2'd0;
            pair_q      <= 20'sd0;
            rowBuf_q[0] <= 20'sd0;
            rowBuf_q[1] <= 20'sd0;
            oValid_q    <= 1'b0;
            oData_q     <= 8'sd0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            pair_q      <= pair_d;
            rowBuf_q[0] <= rowBuf_d[0];
            rowBuf_q[1] <= rowBuf_d[1];
            oValid_q    <= oValid_d;
            oData_q     <= oData_d;
        end
    end

    assign bus.POOL_oValid = oValid_q;
    assign bus.POOL_oData  = oData_q;
    assign bus.POOL_busy   = (state_q == ACCEPT);
    assign bus.POOL_finish = (state_q == DONE) && oValid_q;

endmodule

// File: tb/tb_relu_pool.sv
// Directed bench for relu_pool. Two instances (SHIFT=0 and SHIFT=2) see the
// same stimulus so every frame checks both the unshifted and shifted paths.
module tb_relu_pool;

    logic               clk = 1'b0;
    logic               reset;
    logic               tbStart;
    logic               tbValid;
    logic signed [19:0] tbData;

    int compared   = 0;
    int mismatched = 0;

    logic signed [19:0] frameData [16];
    int                 exp0 [4];
    int                 exp2 [4];
    int                 lastExp0 = 0;
    int                 lastExp2 = 0;

    relu_pool_if poolIf0 ();
    relu_pool_if poolIf2 ();

    assign poolIf0.POOL_start  = tbStart;
    assign poolIf0.POOL_iValid = tbValid;
    assign poolIf0.POOL_iData  = tbData;
    assign poolIf2.POOL_start  = tbStart;
    assign poolIf2.POOL_iValid = tbValid;
    assign poolIf2.POOL_iData  = tbData;

    relu_pool #(.SHIFT(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (poolIf0)
    );

    relu_pool #(.SHIFT(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (poolIf2)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, return just after the rising edge.
    task automatic applyStimulus(input logic s, input logic v, input logic signed [19:0] d);
        @(negedge clk);
        tbStart = s;
        tbValid = v;
        tbData  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic loadRamp(input int base);
        for (int i = 0; i < 16; i++) begin
            frameData[i] = 20'(base + i);
        end
    endtask

    task automatic loadConst(input int value);
        for (int i = 0; i < 16; i++) begin
            frameData[i] = 20'(value);
        end
    endtask

    task automatic setExpect(input int a0, input int b0, input int c0, input int d0,
                             input int a2, input int b2, input int c2, input int d2);
        exp0[0] = a0; exp0[1] = b0; exp0[2] = c0; exp0[3] = d0;
        exp2[0] = a2; exp2[1] = b2; exp2[2] = c2; exp2[3] = d2;
    endtask

    // Start a frame (with a junk sample alongside the start), stream frameData,
    // check every cycle, then try a start while in DONE and confirm it is ignored.
    task automatic runFrame(input string name, input bit gapped);
        int k;
        k = 0;
        applyStimulus(1'b1, 1'b1, 20'sd50000);
        checkOutput({name, "_startBusy"}, int'(poolIf0.POOL_busy), 1);
        checkOutput({name, "_startValid"}, int'(poolIf0.POOL_oValid), 0);
        for (int i = 0; i < 16; i++) begin
            if (gapped) begin
                applyStimulus(1'b0, 1'b0, 20'sd7777);
                checkOutput($sformatf("%s_gap%0d_busy", name, i), int'(poolIf0.POOL_busy), 1);
                checkOutput($sformatf("%s_gap%0d_valid0", name, i), int'(poolIf0.POOL_oValid), 0);
                checkOutput($sformatf("%s_gap%0d_valid2", name, i), int'(poolIf2.POOL_oValid), 0);
                checkOutput($sformatf("%s_gap%0d_hold0", name, i), int'(poolIf0.POOL_oData), lastExp0);
                checkOutput($sformatf("%s_gap%0d_hold2", name, i), int'(poolIf2.POOL_oData), lastExp2);
            end
            applyStimulus(1'b0, 1'b1, frameData[i]);
            checkOutput($sformatf("%s_s%0d_busy", name, i), int'(poolIf0.POOL_busy), (i == 15) ? 0 : 1);
            if (i == 5 || i == 7 || i == 13 || i == 15) begin
                checkOutput($sformatf("%s_s%0d_valid0", name, i), int'(poolIf0.POOL_oValid), 1);
                checkOutput($sformatf("%s_s%0d_data0", name, i), int'(poolIf0.POOL_oData), exp0[k]);
                checkOutput($sformatf("%s_s%0d_valid2", name, i), int'(poolIf2.POOL_oValid), 1);
                checkOutput($sformatf("%s_s%0d_data2", name, i), int'(poolIf2.POOL_oData), exp2[k]);
                checkOutput($sformatf("%s_s%0d_finish0", name, i), int'(poolIf0.POOL_finish), (k == 3) ? 1 : 0);
                checkOutput($sformatf("%s_s%0d_finish2", name, i), int'(poolIf2.POOL_finish), (k == 3) ? 1 : 0);
                lastExp0 = exp0[k];
                lastExp2 = exp2[k];
                k++;
            end else begin
                checkOutput($sformatf("%s_s%0d_valid0", name, i), int'(poolIf0.POOL_oValid), 0);
                checkOutput($sformatf("%s_s%0d_valid2", name, i), int'(poolIf2.POOL_oValid), 0);
                checkOutput($sformatf("%s_s%0d_finish0", name, i), int'(poolIf0.POOL_finish), 0);
            end
        end
        applyStimulus(1'b1, 1'b1, 20'sd9);
        checkOutput({name, "_doneValid"}, int'(poolIf0.POOL_oValid), 0);
        checkOutput({name, "_doneFinish"}, int'(poolIf0.POOL_finish), 0);
        checkOutput({name, "_doneBusy"}, int'(poolIf0.POOL_busy), 0);
        applyStimulus(1'b0, 1'b1, 20'sd9);
        checkOutput({name, "_idleBusy"}, int'(poolIf0.POOL_busy), 0);
        checkOutput({name, "_idleValid"}, int'(poolIf0.POOL_oValid), 0);
        checkOutput({name, "_idleHold0"}, int'(poolIf0.POOL_oData), lastExp0);
    endtask

    initial begin
        reset   = 1'b1;
        tbStart = 1'b0;
        tbValid = 1'b0;
        tbData  = 20'sd0;

        // Reset state, with start and a sample asserted to show reset wins.
        applyStimulus(1'b1, 1'b1, 20'sd77);
        applyStimulus(1'b1, 1'b1, 20'sd77);
        checkOutput("rst_valid", int'(poolIf0.POOL_oValid), 0);
        checkOutput("rst_data", int'(poolIf0.POOL_oData), 0);
        checkOutput("rst_busy", int'(poolIf0.POOL_busy), 0);
        checkOutput("rst_finish", int'(poolIf0.POOL_finish), 0);
        reset = 1'b0;

        // Samples in IDLE are ignored.
        applyStimulus(1'b0, 1'b1, 20'sd100);
        checkOutput("idle_busy", int'(poolIf0.POOL_busy), 0);
        applyStimulus(1'b0, 1'b1, 20'sd100);
        checkOutput("idle_valid", int'(poolIf0.POOL_oValid), 0);

        // Plain ramp.
        loadRamp(0);
        setExpect(5, 7, 13, 15, 1, 1, 3, 3);
        runFrame("ramp", 1'b0);

        // All negative: ReLU clamps to zero.
        loadConst(-300);
        setExpect(0, 0, 0, 0, 0, 0, 0, 0);
        runFrame("neg", 1'b0);

        // Saturation and shift.
        loadConst(-5);
        frameData[0] = 20'sd1000;
        frameData[2] = 20'sd400;
        setExpect(127, 127, 0, 0, 127, 100, 0, 0);
        runFrame("sat", 1'b0);

        // Ramp with a bubble before every sample.
        loadRamp(0);
        setExpect(5, 7, 13, 15, 1, 1, 3, 3);
        runFrame("gap", 1'b1);

        // Partial frame abandoned by reset.
        applyStimulus(1'b1, 1'b0, 20'sd0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 20'(i));
        end
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 20'sd3);
        checkOutput("midrst_valid", int'(poolIf0.POOL_oValid), 0);
        checkOutput("midrst_data", int'(poolIf0.POOL_oData), 0);
        checkOutput("midrst_busy", int'(poolIf0.POOL_busy), 0);
        reset = 1'b0;
        lastExp0 = 0;
        lastExp2 = 0;
        applyStimulus(1'b0, 1'b1, 20'sd200);
        checkOutput("midrst_idleValid", int'(poolIf0.POOL_oValid), 0);
        loadRamp(16);
        setExpect(21, 23, 29, 31, 5, 5, 7, 7);
        runFrame("afterRst", 1'b0);

        // Partial frame abandoned by a second start.
        applyStimulus(1'b1, 1'b0, 20'sd0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 20'sd100);
        end
        loadRamp(0);
        setExpect(5, 7, 13, 15, 1, 1, 3, 3);
        runFrame("restart", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/relu_pool.md
RELU_POOL -- requirements
Module: relu_pool

Interface
REQ-001 Parameter SHIFT, default 2: arithmetic right-shift applied to each pooled value before saturation (0..12).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 POOL_start  input  1  one-cycle pulse; arms block for a new 4x4 frame.
REQ-005 POOL_iValid  input  1  POOL_iData carries a sample this cycle.
REQ-006 POOL_iData  input  20 signed  convolution result stream; 16 samples per frame, row-major, row 0 col 0 first.
REQ-007 POOL_oValid  output  1  POOL_oData valid this cycle.
REQ-008 POOL_oData  output  8 signed  pooled, rectified, scaled, saturated result; 4 per frame, row-major.
REQ-009 POOL_busy  output  1  high while in state ACCEPT.
REQ-010 POOL_finish  output  1  one-cycle pulse coincident with the 4th POOL_oValid of a frame.

Function
REQ-011 State machine SHALL have states IDLE, ACCEPT, DONE; reset state IDLE.
REQ-012 IDLE -> ACCEPT on POOL_start; POOL_iValid in IDLE ignored.
REQ-013 ACCEPT -> DONE on the cycle the 16th accepted sample is taken; DONE -> IDLE unconditionally next cycle.
REQ-014 Accepted sample = POOL_iValid high in ACCEPT; row counter r (0..3) and column counter c (0..3) advance only on accepted samples, c wraps 3->0 incrementing r.
REQ-015 Gaps in POOL_iValid SHALL stall counters without altering stored state or outputs.
REQ-016 On accepted sample with c even: sample stored in pair register.
REQ-017 On accepted sample with c odd: pair max m = signed max(pair register, sample).
REQ-018 r even, c odd: m written to row buffer entry c>>1 (2 entries, 20 bit signed).
REQ-019 r odd, c odd: window max w = signed max(row buffer[c>>1], m); output path triggered.
REQ-020 Output path: y = (w < 0) ? 0 : w; y = y >>> SHIFT; POOL_oData = (y > 127) ? 127 : y[7:0].
REQ-021 Latency: POOL_oValid and POOL_oData registered, asserted exactly 1 cycle after the accepted sample that triggered REQ-019; POOL_oValid high for one cycle per result.
REQ-022 POOL_oData SHALL hold its last value when POOL_oValid low.
REQ-023 Output order: windows (0,0),(0,1),(1,0),(1,1) = after samples 5, 7, 13, 15 (0-based index).
REQ-024 POOL_finish SHALL pulse in the same cycle as the 4th POOL_oValid (state DONE).
REQ-025 POOL_start while ACCEPT: frame restarts; r, c cleared, pair register and row buffer contents discarded, no output for the abandoned frame; POOL_iValid in the same cycle as POOL_start ignored.
REQ-026 POOL_start in DONE: ignored; block returns to IDLE, new start required.
REQ-027 Equal values in max comparisons: either operand (identical result).
REQ-028 Max comparisons and ReLU SHALL be signed 20-bit; no intermediate overflow permitted.

Reset
REQ-029 On reset: state IDLE, r = c = 0, POOL_oValid = 0, POOL_oData = 0, POOL_busy = 0, POOL_finish = 0, pair register and row buffer cleared to 0.
REQ-030 Reset SHALL take priority over POOL_start and POOL_iValid in the same cycle.
REQ-031 Reset mid-frame: partial frame abandoned, no further outputs until a new POOL_start and full frame.

Verification
REQ-032 SHIFT=0, start, samples 0..15 continuous -> POOL_oData 5,7,13,15 one cycle after samples 5,7,13,15; POOL_finish with 15.
REQ-033 SHIFT=0, all 16 samples = -300 -> four outputs of 0; finish asserted.
REQ-034 SHIFT=2, samples {1000 at index 0, 400 at index 2, -5 elsewhere} -> outputs 127 (saturated), 100, 0, 0.
REQ-035 SHIFT=0, ramp 0..15 with POOL_iValid toggling every cycle -> same outputs 5,7,13,15, exactly 4 POOL_oValid pulses, busy high throughout.
REQ-036 Start, 7 samples, reset, start, ramp 16..31 -> only outputs 21,23,29,31; no output from the abandoned frame.
REQ-037 Start, 9 samples of 100, POOL_start again, ramp 0..15 (SHIFT=0) -> outputs 5,7,13,15 only.
